// File: rtl/mux_bus_arbiter.sv
// mux_bus_arbiter
//   Round-robin arbiter sharing one 4x1 bus multiplexer among four requesters.
//   Each owner holds the bus for at most MAX_HOLD cycles (0 = unlimited), and
//   one dead turnaround cycle with no grant separates consecutive owners.
//
// Optional feature macro: ARB_LOCK_EN (adds the lock input; while lock is high
//   during a tenure, the MAX_HOLD release is suppressed).
//
// Parameters:
//   MAX_HOLD - maximum consecutive grant cycles per tenure, 0 = unlimited
//   HOLD_W   - hold counter width, MAX_HOLD <= 2**HOLD_W - 1
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   req   in   [3:0] request, bit i = requester i
//   lock  in   tenure lock (ARB_LOCK_EN only)
//   grant out  [3:0] one-hot grant, zero when no owner (registered)
//   s1    out  mux select LSB, owner index bit 0 (registered)
//   s2    out  mux select MSB, owner index bit 1 (registered)
//   busy  out  high while a grant is active (registered)
module mux_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] grant,
    output logic       s1,
    output logic       s2,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_TURN = 2'd2;

    localparam bit              HOLD_EN    = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};
    // Count value seen on the edge that closes a full MAX_HOLD-cycle tenure.
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        sel_q,   sel_d;
    logic              busy_q,  busy_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [1:0]        last_q,  last_d;

    logic              win_vld_c;
    logic [1:0]        win_idx_c;
    logic              lock_c;
    logic              release_c;

`ifdef ARB_LOCK_EN
    assign lock_c = lock;
`else
    assign lock_c = 1'b0;
`endif

    // Round-robin pick: first set request scanning upward from last+1 with wrap.
    always_comb begin
        logic [1:0] cand;
        win_vld_c = 1'b0;
        win_idx_c = 2'd0;
        cand      = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = last_q + 2'd1 + 2'(k);
            if (req[cand]) begin
                win_vld_c = 1'b1;
                win_idx_c = cand;
            end
        end
    end

    // Owner leaves when its request drops or its tenure budget is used up.
    assign release_c = !req[sel_q]
                     || (HOLD_EN && (hold_q == HOLD_LIMIT) && !lock_c);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE, ST_TURN: begin
                grant_d = 4'b0000;
                busy_d  = 1'b0;
                if (win_vld_c) begin
                    state_d = ST_BUSY;
                    grant_d = 4'b0001 << win_idx_c;
                    sel_d   = win_idx_c;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                // Select lines keep the old owner through the dead cycle.
                if (release_c) begin
                    state_d = ST_TURN;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                    last_d  = sel_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'b00;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign grant = grant_q;
    assign s1    = sel_q[0];
    assign s2    = sel_q[1];
    assign busy  = busy_q;

endmodule
